edac_byte_store: RTL and testbench

- Request-driven byte store that sequences the dual 4-bit EDAC stage and sits directly upstream of it.
- Drives the EDAC's en/READ/DIN and consumes its registered 32-bit output.
- Holds the resulting 32-bit codewords in an internal DEPTH-word array.
- Returns decoded bytes, with retry on uncorrectable results and a sticky error flag.

---
 rtl/edac_byte_store_pkg.sv | 19 +
 rtl/edac_cw_ram.sv | 31 +++
 rtl/edac_byte_store.sv | 166 ++++++++++++++++
 tb/tb_edac_byte_store.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edac_byte_store_pkg.sv
// Shared definitions for the EDAC byte store: FSM state encoding and EDAC interface constants.
package edac_byte_store_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENC,
    ST_ENC_WAIT,
    ST_DEC,
    ST_DEC_WAIT,
    ST_RESP,
    ST_SCRUB_ENC,
    ST_SCRUB_WAIT
  } state_e;

  localparam logic [31:0] EDAC_ERROR_CODE = 32'hFFFF_FFFF;
  localparam logic        EDAC_MODE_READ  = 1'b1;
  localparam logic        EDAC_MODE_WRITE = 1'b0;

endpackage

// File: rtl/edac_cw_ram.sv
// DEPTH x 32 codeword array: asynchronous read, FSM and debug synchronous write ports.
// When both ports hit the same word in one cycle, the FSM port wins.
module edac_cw_ram
  import edac_byte_store_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_fsm_we,
  input  logic [ADDR_W-1:0] i_fsm_addr,
  input  logic [31:0]       i_fsm_wdata,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [31:0]       i_dbg_wdata,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] r_mem [DEPTH];

  // The FSM write is issued last so it overrides a same-address debug write.
  always_ff @(posedge i_clk) begin
    if (i_dbg_we) r_mem[i_dbg_addr] <= i_dbg_wdata;
    if (i_fsm_we) r_mem[i_fsm_addr] <= i_fsm_wdata;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/edac_byte_store.sv
// Request-driven byte store sequencing an external dual-nibble EDAC stage.
// Optional scrub write-back of corrected codewords: define EDAC_SCRUB_WB_EN.
module edac_byte_store
  import edac_byte_store_pkg::*;
#(
  parameter int          ADDR_W     = 4,
  parameter logic [31:0] ERROR_CODE = EDAC_ERROR_CODE,
  parameter int          MAX_RETRY  = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              err_sticky,
  output logic              edac_en,
  output logic              edac_read,
  output logic [31:0]       edac_din,
  input  logic [31:0]       edac_dout,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata
);

  localparam logic [2:0] MAX_RETRY_3B = 3'(MAX_RETRY);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic              r_err;
  logic              r_sticky;
  logic [2:0]        r_retry;
  logic              r_read_hold;
  logic [31:0]       r_din_hold;
  logic              w_en;
  logic              w_read;
  logic [31:0]       w_din;
  logic [31:0]       w_rd_data;
  logic              w_mem_we;
  logic              w_dec_fail;

  edac_cw_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk       (CLK),
    .i_fsm_we    (w_mem_we),
    .i_fsm_addr  (r_addr),
    .i_fsm_wdata (edac_dout),
    .i_dbg_we    (dbg_we),
    .i_dbg_addr  (dbg_addr),
    .i_dbg_wdata (dbg_wdata),
    .i_rd_addr   (r_addr),
    .o_rd_data   (w_rd_data)
  );

  assign w_dec_fail = (edac_dout == ERROR_CODE);
  assign w_mem_we   = (r_state == ST_ENC_WAIT) || (r_state == ST_SCRUB_WAIT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:       if (req_valid) w_state_next = req_write ? ST_ENC : ST_DEC;
      ST_ENC:        w_state_next = ST_ENC_WAIT;
      ST_ENC_WAIT:   w_state_next = ST_RESP;
      ST_DEC:        w_state_next = ST_DEC_WAIT;
      ST_DEC_WAIT: begin
        if (w_dec_fail) begin
          w_state_next = (r_retry < MAX_RETRY_3B) ? ST_DEC : ST_RESP;
        end else begin
`ifdef EDAC_SCRUB_WB_EN
          w_state_next = ST_SCRUB_ENC;
`else
          w_state_next = ST_RESP;
`endif
        end
      end
      ST_SCRUB_ENC:  w_state_next = ST_SCRUB_WAIT;
      ST_SCRUB_WAIT: w_state_next = ST_RESP;
      ST_RESP:       w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  // EDAC mode and data hold their previous values whenever the stage is not enabled.
  always_comb begin
    w_en   = 1'b0;
    w_read = r_read_hold;
    w_din  = r_din_hold;
    case (r_state)
      ST_ENC: begin
        w_en   = 1'b1;
        w_read = EDAC_MODE_WRITE;
        w_din  = {24'b0, r_wdata};
      end
      ST_DEC: begin
        w_en   = 1'b1;
        w_read = EDAC_MODE_READ;
        w_din  = w_rd_data;
      end
      ST_SCRUB_ENC: begin
        w_en   = 1'b1;
        w_read = EDAC_MODE_WRITE;
        w_din  = {24'b0, r_rdata};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_sticky    <= 1'b0;
      r_retry     <= '0;
      r_read_hold <= 1'b0;
      r_din_hold  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_read_hold <= w_read;
      r_din_hold  <= w_din;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_DEC_WAIT: begin
          if (w_dec_fail) begin
            if (r_retry < MAX_RETRY_3B) begin
              r_retry <= r_retry + 3'd1;
            end else begin
              r_err    <= 1'b1;
              r_sticky <= 1'b1;
              r_rdata  <= '0;
            end
          end else begin
            r_rdata <= edac_dout[7:0];
          end
        end
        ST_RESP: r_retry <= '0;
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign err_sticky = r_sticky;
  assign edac_en    = w_en;
  assign edac_read  = w_read;
  assign edac_din   = w_din;

endmodule

// File: tb/tb_edac_byte_store.sv
// Self-checking bench for edac_byte_store with a behavioural dual-nibble EDAC model.
module tb_edac_byte_store;

  localparam int          ADDR_W    = 4;
  localparam int          DEPTH     = 16;
  localparam int          MAX_RETRY = 2;
  localparam logic [31:0] ERR_CODE  = 32'hFFFF_FFFF;

  logic              CLK = 1'b0;
  logic              reset;
  logic              req_valid, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              req_ready, rsp_valid, rsp_err, err_sticky;
  logic [7:0]        rsp_rdata;
  logic              edac_en, edac_read;
  logic [31:0]       edac_din;
  logic [31:0]       edac_dout = '0;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cwMem   [DEPTH];
  logic [7:0]  byteMem [DEPTH];
  bit          modelSticky = 0;

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] expRdata;
    bit         expErr;
    int         expLat;
  } vec_t;

  vec_t vecs[8];

  edac_byte_store #(.ADDR_W(ADDR_W), .ERROR_CODE(ERR_CODE), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_sticky(err_sticky),
    .edac_en(edac_en), .edac_read(edac_read), .edac_din(edac_din), .edac_dout(edac_dout),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata)
  );

  always #5 CLK = ~CLK;

  // Each nibble is stored as four copies, alternately inverted; a 2-2 vote is uncorrectable.
  function automatic logic [15:0] encNib(input logic [3:0] n);
    return {n, ~n, n, ~n};
  endfunction

  function automatic logic [31:0] encodeByte(input logic [7:0] b);
    return {encNib(b[7:4]), encNib(b[3:0])};
  endfunction

  function automatic bit decNib(input logic [15:0] h, output logic [3:0] n);
    bit ok;
    ok = 1'b1;
    n  = '0;
    for (int j = 0; j < 4; j++) begin
      int v;
      v = int'(h[12+j]) + int'(!h[8+j]) + int'(h[4+j]) + int'(!h[j]);
      if (v >= 3)      n[j] = 1'b1;
      else if (v <= 1) n[j] = 1'b0;
      else             ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [31:0] decodeWord(input logic [31:0] cw);
    logic [3:0] hi, lo;
    bit okH, okL;
    okH = decNib(cw[31:16], hi);
    okL = decNib(cw[15:0], lo);
    if (okH && okL) return {24'b0, hi, lo};
    return ERR_CODE;
  endfunction

  // Registered EDAC stage: result appears the cycle after edac_en.
  always @(posedge CLK) begin
    if (edac_en) edac_dout <= edac_read ? decodeWord(edac_din) : encodeByte(edac_din[7:0]);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [3:0] a, input logic [7:0] d,
                               output int lat, output logic [7:0] rd, output bit er,
                               output bit stk, output int pulses, output logic [31:0] din);
    int w;
    w = 0;
    @(negedge CLK);
    while (!req_ready && w < 20) begin
      @(negedge CLK);
      w++;
    end
    checkOutput("readyWait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge CLK);
    req_valid = 1'b0;
    lat = -1; rd = 'x; er = 1'b0; stk = 1'b0; pulses = 0; din = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) din = edac_din;
      if (edac_en) pulses++;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; stk = err_sticky;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic dbgWrite(input logic [3:0] a, input logic [31:0] cw);
    @(negedge CLK);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = cw;
    @(negedge CLK);
    dbg_we = 1'b0;
    cwMem[a] = cw;
  endtask

  // Expected results come from the codeword model and the retry/latency rules.
  task automatic doCheckedOp(input bit wr, input logic [3:0] a, input logic [7:0] d);
    int lat, pulses;
    logic [7:0] rd;
    bit er, stk;
    logic [31:0] din, dec;
    bit expErr;
    if (wr) begin
      applyStimulus(1'b1, a, d, lat, rd, er, stk, pulses, din);
      cwMem[a] = encodeByte(d);
      byteMem[a] = d;
      checkOutput("wrLatency", lat, 32'd3);
      checkOutput("wrErr", {31'b0, er}, 32'd0);
      checkOutput("wrPulses", pulses, 32'd1);
    end else begin
      dec = decodeWord(cwMem[a]);
      expErr = (dec == ERR_CODE);
      applyStimulus(1'b0, a, 8'h00, lat, rd, er, stk, pulses, din);
      if (expErr) modelSticky = 1'b1;
      checkOutput("rdStoredCw", din, cwMem[a]);
      checkOutput("rdLatency", lat, expErr ? 32'(3 + 2 * MAX_RETRY) : 32'd3);
      checkOutput("rdPulses", pulses, expErr ? 32'(MAX_RETRY + 1) : 32'd1);
      checkOutput("rdErr", {31'b0, er}, {31'b0, expErr});
      checkOutput("rdData", {24'b0, rd}, expErr ? 32'd0 : {24'b0, dec[7:0]});
      checkOutput("rdSticky", {31'b0, stk}, {31'b0, modelSticky});
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, pulses, i, lowCnt, cyc, enCnt, rspCnt;
    logic [7:0] rd;
    bit er, stk;
    logic [31:0] din, mask;
    logic [3:0] b2bAddr [4];
    logic [7:0] b2bData [4];

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 1'b0, 3};
    vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 3};
    vecs[2] = '{1'b1, 4'd5,  8'h3C, 8'h00, 1'b0, 3};
    vecs[3] = '{1'b1, 4'd9,  8'h00, 8'h00, 1'b0, 3};
    vecs[4] = '{1'b0, 4'd9,  8'h00, 8'h00, 1'b0, 3};
    vecs[5] = '{1'b1, 4'd15, 8'hFF, 8'h00, 1'b0, 3};
    vecs[6] = '{1'b0, 4'd15, 8'h00, 8'hFF, 1'b0, 3};
    vecs[7] = '{1'b0, 4'd5,  8'h00, 8'h3C, 1'b0, 3};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    checkOutput("rstReady", {31'b0, req_ready}, 32'd1);
    checkOutput("rstRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstRdata", {24'b0, rsp_rdata}, 32'd0);
    checkOutput("rstErr", {31'b0, rsp_err}, 32'd0);
    checkOutput("rstSticky", {31'b0, err_sticky}, 32'd0);
    checkOutput("rstEn", {31'b0, edac_en}, 32'd0);
    checkOutput("rstRead", {31'b0, edac_read}, 32'd0);
    checkOutput("rstDin", edac_din, 32'd0);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].wr, vecs[v].addr, vecs[v].data, lat, rd, er, stk, pulses, din);
      if (vecs[v].wr) begin
        cwMem[vecs[v].addr] = encodeByte(vecs[v].data);
      end else begin
        checkOutput("tblData", {24'b0, rd}, {24'b0, vecs[v].expRdata});
        checkOutput("tblCw", din, cwMem[vecs[v].addr]);
      end
      checkOutput("tblLatency", lat, vecs[v].expLat);
      checkOutput("tblErr", {31'b0, er}, {31'b0, vecs[v].expErr});
    end

    // One flipped bit in each half is corrected without retry.
    dbgWrite(4'd5, encodeByte(8'h3C) ^ 32'h0001_0001);
    applyStimulus(1'b0, 4'd5, 8'h00, lat, rd, er, stk, pulses, din);
    checkOutput("flipData", {24'b0, rd}, 32'h3C);
    checkOutput("flipErr", {31'b0, er}, 32'd0);
    checkOutput("flipLatency", lat, 32'd3);
    checkOutput("flipPulses", pulses, 32'd1);
    checkOutput("flipSticky", {31'b0, stk}, 32'd0);

    dbgWrite(4'd7, 32'h0000_FFFF);
    applyStimulus(1'b0, 4'd7, 8'h00, lat, rd, er, stk, pulses, din);
    modelSticky = 1'b1;
    checkOutput("uncLatency", lat, 32'd7);
    checkOutput("uncPulses", pulses, 32'd3);
    checkOutput("uncErr", {31'b0, er}, 32'd1);
    checkOutput("uncData", {24'b0, rd}, 32'd0);
    checkOutput("uncSticky", {31'b0, stk}, 32'd1);

    // Back-to-back writes with req_valid held high throughout.
    for (int k = 0; k < 4; k++) begin
      b2bAddr[k] = 4'(10 + k);
      b2bData[k] = 8'($urandom);
    end
    i = 0; lowCnt = 0; cyc = 0; enCnt = 0; rspCnt = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = b2bAddr[0]; req_wdata = b2bData[0];
    while (i < 4 && cyc < 80) begin
      if (edac_en) enCnt++;
      if (rsp_valid) rspCnt++;
      if (req_ready) begin
        if (i > 0) checkOutput("b2bReadyLow", lowCnt, 32'd3);
        lowCnt = 0;
        i++;
      end else begin
        lowCnt++;
      end
      @(negedge CLK);
      cyc++;
      if (i < 4) begin
        req_addr = b2bAddr[i]; req_wdata = b2bData[i];
      end else begin
        req_valid = 1'b0;
      end
    end
    checkOutput("b2bAccepted", i, 32'd4);
    for (int k = 0; k < 6; k++) begin
      if (edac_en) enCnt++;
      if (rsp_valid) rspCnt++;
      @(negedge CLK);
    end
    checkOutput("b2bPulses", enCnt, 32'd4);
    checkOutput("b2bResponses", rspCnt, 32'd4);
    for (int k = 0; k < 4; k++) begin
      cwMem[b2bAddr[k]] = encodeByte(b2bData[k]);
      doCheckedOp(1'b0, b2bAddr[k], 8'h00);
    end

    // Reset while waiting on a decode result.
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    @(negedge CLK);
    req_valid = 1'b0;
    checkOutput("abortDecEn", {31'b0, edac_en}, 32'd1);
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    modelSticky = 1'b0;
    checkOutput("abortReady", {31'b0, req_ready}, 32'd1);
    checkOutput("abortRspValid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("abortSticky", {31'b0, err_sticky}, 32'd0);
    checkOutput("abortDin", edac_din, 32'd0);
    rspCnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) rspCnt++;
      @(negedge CLK);
    end
    checkOutput("abortNoRsp", rspCnt, 32'd0);
    doCheckedOp(1'b0, 4'd3, 8'h00);

    // Randomized traffic against the codeword model.
    for (int a = 0; a < DEPTH; a++) doCheckedOp(1'b1, 4'(a), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [3:0] a;
      sel = int'($urandom_range(0, 9));
      a = 4'($urandom_range(0, DEPTH - 1));
      if (sel < 4) begin
        doCheckedOp(1'b1, a, 8'($urandom));
      end else if (sel < 8) begin
        doCheckedOp(1'b0, a, 8'h00);
      end else begin
        mask = '0;
        for (int f = 0; f < int'($urandom_range(1, 2)); f++) mask[$urandom_range(0, 31)] = 1'b1;
        dbgWrite(a, encodeByte(byteMem[a]) ^ mask);
        doCheckedOp(1'b0, a, 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
